// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin issue scheduler sharing one fixed-latency FP16 sqrt pipe.
// Each operand is tagged with its requester ID. Results come back in issue order
// through a response FIFO. A credit count covering the tag pipe and the FIFO keeps
// the FIFO from overflowing, so the sqrt pipe never needs backpressure.
// Optional build macro: SQRT_SCHED_PERF_EN adds the perf_issued / perf_stall counters.
module sqrt_sched #(
    parameter int  N_REQ        = 4,
    parameter int  SQRT_LATENCY = 7,
    parameter int  FIFO_DEPTH   = 8,
    localparam int IW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*16-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                sq_valid_in,
    output logic [15:0]         sq_in,
    input  logic                sq_valid_out,
    input  logic [15:0]         sq_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_data,
    output logic [IW-1:0]       rsp_id,
    output logic                lat_err
`ifdef SQRT_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(2 * SQRT_LATENCY + 1);

    logic [IW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]          credits_reg, credits_next;
    logic                   issue_ok;
    logic                   any_grant;
    logic [IW-1:0]          grant_id;
    logic [N_REQ-1:0]       grant;
    logic [IW-1:0]          cand_id [N_REQ];
    logic [SQRT_LATENCY-1:0] tag_valid_reg;
    logic [IW-1:0]          tag_id_reg [SQRT_LATENCY];
    logic                   push, pop;
    logic [15:0]            data_mem [FIFO_DEPTH];
    logic [IW-1:0]          id_mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]            count_reg;
    logic [BW-1:0]          blank_reg;

    // Credits are judged on the registered count only; reset also blocks any grant.
    assign issue_ok = !RST && (credits_reg < CW'(FIFO_DEPTH));

    // Candidate requester for each search offset from the round-robin pointer.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum         = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
        assign cand_id[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
    end

    // Pick the first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_grant = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_grant && issue_ok && req_valid[cand_id[i]]) begin
                any_grant = 1'b1;
                grant_id  = cand_id[i];
            end
        end
    end

    // One-hot grant vector.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = any_grant && (grant_id == IW'(gi));
    end

    assign req_ready   = grant;
    assign sq_valid_in = any_grant;

    // Forward the granted operand to the sqrt pipe, zero when idle.
    always_comb begin
        sq_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sq_in = req_data[16*i +: 16];
        end
    end

    // Pointer moves just past the winner; holds with no grant.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (any_grant) rr_ptr_next = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    assign push = tag_valid_reg[SQRT_LATENCY-1];
    assign pop  = rsp_valid && rsp_ready;

    // Credit accounting: issue takes one, pop returns one.
    always_comb begin
        credits_next = credits_reg;
        if (any_grant && !pop)      credits_next = credits_reg + 1'b1;
        else if (!any_grant && pop) credits_next = credits_reg - 1'b1;
    end

    // Arbiter pointer and credit registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_reg  <= '0;
            credits_reg <= '0;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            credits_reg <= credits_next;
        end
    end

    // Tag pipe: tracks {valid, id} alongside the sqrt datapath.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_valid_reg <= '0;
            for (int i = 0; i < SQRT_LATENCY; i++) tag_id_reg[i] <= '0;
        end else begin
            tag_valid_reg[0] <= any_grant;
            tag_id_reg[0]    <= grant_id;
            for (int i = 1; i < SQRT_LATENCY; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
        end
    end

    // Response storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= sq_out;
            id_mem[wr_ptr_reg]   <= tag_id_reg[SQRT_LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
    end

    assign rsp_valid = (count_reg != '0);
    assign rsp_data  = rsp_valid ? data_mem[rd_ptr_reg] : '0;
    assign rsp_id    = rsp_valid ? id_mem[rd_ptr_reg] : '0;

    // Sticky latency check; unmatched sqrt results are ignored for a while after reset
    // so that results still draining from before reset are not flagged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blank_reg <= BW'(2 * SQRT_LATENCY);
            lat_err   <= 1'b0;
        end else begin
            if (blank_reg != '0) blank_reg <= blank_reg - 1'b1;
            if (push && !sq_valid_out)                          lat_err <= 1'b1;
            if (!push && sq_valid_out && (blank_reg == '0))     lat_err <= 1'b1;
        end
    end

`ifdef SQRT_SCHED_PERF_EN
    // Performance counters: grants issued and cycles starved of credit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (any_grant) perf_issued <= perf_issued + 32'd1;
            if ((|req_valid) && !issue_ok) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: directed bench for sqrt_sched with a behavioural 7-cycle sqrt pipe,
// an expected-response queue filled at issue time and a monitor that checks each pop.
module tb_sqrt_sched;
    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        sq_valid_in;
    logic [15:0] sq_in;
    logic        sq_valid_out;
    logic [15:0] sq_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        lat_err;
`ifdef SQRT_SCHED_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    sqrt_sched #(.N_REQ(4), .SQRT_LATENCY(7), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sq_valid_in(sq_valid_in), .sq_in(sq_in),
        .sq_valid_out(sq_valid_out), .sq_out(sq_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .lat_err(lat_err)
`ifdef SQRT_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    // Behavioural sqrt: table of exact FP16 square roots used by the vectors.
    function automatic logic [15:0] sqrt_lut(input logic [15:0] x);
        case (x)
            16'h3400: return 16'h3800;  // 0.25 -> 0.5
            16'h3C00: return 16'h3C00;  // 1    -> 1
            16'h4400: return 16'h4000;  // 4    -> 2
            16'h4880: return 16'h4200;  // 9    -> 3
            16'h4C00: return 16'h4400;  // 16   -> 4
            16'h5400: return 16'h4800;  // 64   -> 8
            default:  return 16'hFFFF;
        endcase
    endfunction

    // Non-stallable sqrt pipe model; it is not reset, like the real datapath.
    logic [6:0]  pv = '0;
    logic [15:0] pd [7];
    logic        inject;
    always @(posedge CLK) begin
        pv    <= {pv[5:0], sq_valid_in};
        pd[0] <= sq_in;
        for (int k = 1; k < 7; k++) pd[k] <= pd[k-1];
    end
    assign sq_valid_out = pv[6] | inject;
    assign sq_out       = sqrt_lut(pd[6]);

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_res [4];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        req_data   = {d3, d2, d1, d0};
        exp_res[0] = e0;
        exp_res[1] = e1;
        exp_res[2] = e2;
        exp_res[3] = e3;
    endtask

    task automatic reset_checks();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sq_valid_in", 32'(sq_valid_in), 32'd0);
        check("rst_sq_in", 32'(sq_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_lat_err", 32'(lat_err), 32'd0);
`ifdef SQRT_SCHED_PERF_EN
        check("rst_perf_issued", perf_issued, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
    endtask

    // Assert reset (inputs other than rsp_ready/inject untouched), check outputs, release.
    task automatic apply_reset();
        step();
        RST       = 1'b1;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        sb.delete();
        @(negedge CLK);
        reset_checks();
        step();
        step();
        RST = 1'b0;
    endtask

    // One cycle of stimulus: drive, then check grant and forwarded operand at negedge.
    task automatic issue_cycle(input logic [3:0] valid, input logic [3:0] exp_grant,
                               input logic rdy);
        int   gid;
        exp_t e;
        step();
        req_valid = valid;
        rsp_ready = rdy;
        @(negedge CLK);
        check("req_ready", 32'(req_ready), 32'(exp_grant));
        check("sq_valid_in", 32'(sq_valid_in), 32'(|exp_grant));
        if (exp_grant != 4'd0) begin
            gid = 0;
            for (int i = 0; i < 4; i++) if (exp_grant[i]) gid = i;
            check("sq_in", 32'(sq_in), 32'(req_data[16*gid +: 16]));
            e.id   = 2'(gid);
            e.data = exp_res[gid];
            sb.push_back(e);
            $display("issue id=%0d operand=%h", gid, req_data[16*gid +: 16]);
        end
    endtask

    // Monitor: compares every popped response against the head of the expected queue.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && rsp_valid && rsp_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    $display("response id=%0d data=%h (expected id=%0d data=%h)",
                             rsp_id, rsp_data, e.id, e.data);
                end
            end
        end
    endtask

    initial begin
        int found;
        int pops_before;
        int stale;
        RST       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        fork
            monitor();
        join_none
        apply_reset();

        // Single request: requester 2, 4.0 -> 2.0, response 8 cycles after issue.
        set_data(16'h0000, 16'h0000, 16'h4400, 16'h0000,
                 16'h0000, 16'h0000, 16'h4000, 16'h0000);
        issue_cycle(4'b0100, 4'b0100, 1'b1);
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            issue_cycle(4'b0000, 4'b0000, 1'b1);
            if (rsp_valid && found == 0) found = k;
        end
        check("single_latency", 32'(found), 32'd8);
        check("single_drained", 32'(sb.size()), 32'd0);

        // Fairness: all valid, grants rotate 0,1,2,3,... one per cycle.
        apply_reset();
        set_data(16'h5400, 16'h3400, 16'h3C00, 16'h4400,
                 16'h4800, 16'h3800, 16'h3C00, 16'h4000);
        for (int c = 0; c < 8; c++) issue_cycle(4'hF, 4'(1 << (c % 4)), 1'b1);
        for (int c = 0; c < 20; c++) issue_cycle(4'h0, 4'h0, 1'b1);
        check("fair_drained", 32'(sb.size()), 32'd0);

        // Credit stall: 8 grants with rsp_ready low, then none.
        apply_reset();
        set_data(16'h3C00, 16'h4400, 16'h4C00, 16'h4880,
                 16'h3C00, 16'h4000, 16'h4400, 16'h4200);
        for (int c = 0; c < 8; c++) issue_cycle(4'hF, 4'(1 << (c % 4)), 1'b0);   // cycles 0..7
        for (int c = 0; c < 10; c++) issue_cycle(4'hF, 4'h0, 1'b0);             // cycles 8..17
        issue_cycle(4'hF, 4'h0, 1'b1);     // cycle 18: one pop, no grant yet
        issue_cycle(4'hF, 4'b0001, 1'b0);  // cycle 19: exactly one new grant
        issue_cycle(4'hF, 4'h0, 1'b0);
        issue_cycle(4'hF, 4'h0, 1'b0);
        for (int c = 22; c < 26; c++) issue_cycle(4'h0, 4'h0, 1'b0);

        // Simultaneous push/pop: cycle 26 pops the head as the cycle-19 result arrives.
        pops_before = n_pop;
        for (int c = 0; c < 16; c++) issue_cycle(4'h0, 4'h0, 1'b1);
        check("pushpop_pop_count", 32'(n_pop - pops_before), 32'd8);
        check("pushpop_drained", 32'(sb.size()), 32'd0);
        check("pushpop_empty", 32'(rsp_valid), 32'd0);

        // Latency mismatch: a stray sqrt valid with no tag outstanding.
        check("laterr_before", 32'(lat_err), 32'd0);
        inject = 1'b1;
        issue_cycle(4'h0, 4'h0, 1'b1);
        inject = 1'b0;
        check("laterr_set", 32'(lat_err), 32'd1);
        for (int c = 0; c < 5; c++) issue_cycle(4'h0, 4'h0, 1'b1);
        check("laterr_sticky", 32'(lat_err), 32'd1);
        check("laterr_no_push", 32'(rsp_valid), 32'd0);

        // Mid-flight reset with 5 results outstanding.
        apply_reset();
        set_data(16'h4400, 16'h4C00, 16'h4880, 16'h3C00,
                 16'h4000, 16'h4400, 16'h4200, 16'h3C00);
        for (int c = 0; c < 5; c++) issue_cycle(4'hF, 4'(1 << (c % 4)), 1'b1);
        apply_reset();                     // req_valid stays high through reset
        req_valid = 4'h0;
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            issue_cycle(4'h0, 4'h0, 1'b1);
            if (rsp_valid) stale++;
        end
        check("midreset_no_stale", 32'(stale), 32'd0);
        check("midreset_lat_err", 32'(lat_err), 32'd0);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
